// File: rtl/apu_serial_frontend.sv
`default_nettype none
// ============================================================================
// Module   : apu_serial_frontend
// Purpose  : 8N1 UART receiver and two-byte register-write packet decoder,
//            with link-activity, heartbeat and framing-error indicators.
// Revision : 1.0  initial release
// ============================================================================
module apu_serial_frontend #(
    parameter int CLKRATE      = 1_789_773,
    parameter int BAUDRATE     = 9600,
    parameter int ADDR_WIDTH   = 5,
    parameter int TIMEOUT_BITS = 16,
    parameter int LINK_CYCLES  = 89_488
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  frame_err,
    output logic                  link,
    output logic                  blink
);

    localparam int c_baud_div  = (CLKRATE + BAUDRATE / 2) / BAUDRATE;
    localparam int c_half      = c_baud_div / 2;
    localparam int c_blink_div = CLKRATE / 2;
    localparam int c_timeout   = TIMEOUT_BITS * c_baud_div;
    localparam int c_bit_w     = $clog2(c_baud_div + 1);
    localparam int c_to_w      = $clog2(c_timeout + 1);
    localparam int c_link_w    = $clog2(LINK_CYCLES + 1);
    localparam int c_blink_w   = $clog2(c_blink_div + 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_stop  = 3'd3;
    localparam logic [2:0] c_st_break = 3'd4;

    localparam logic [0:0] c_ps_wait_addr = 1'b0;
    localparam logic [0:0] c_ps_wait_data = 1'b1;

    logic                  rx_meta_q, rx_meta_d;
    logic                  rxs_q, rxs_d;
    logic                  rxs_prev_q, rxs_prev_d;
    logic [2:0]            settle_q, settle_d;
    logic [2:0]            rx_state_q, rx_state_d;
    logic [c_bit_w-1:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q, shift_d;
    logic [0:0]            ps_q, ps_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [c_to_w-1:0]     to_cnt_q, to_cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  frame_err_q, frame_err_d;
    logic [c_link_w-1:0]   link_cnt_q, link_cnt_d;
    logic [c_blink_w-1:0]  blink_cnt_q, blink_cnt_d;
    logic                  blink_q, blink_d;

    logic                  w_expire;
    logic                  w_start_edge;
    logic                  w_byte_valid;
    logic                  w_frame_bad;

    // settle_q fills with ones after reset; until then rxs/rxs_prev still hold
    // reset values and must not be mistaken for a falling edge.
    always_comb begin
        rx_meta_d    = rx;
        rxs_d        = rx_meta_q;
        rxs_prev_d   = rxs_q;
        settle_d     = {settle_q[1:0], 1'b1};
    end

    assign w_start_edge = settle_q[2] && rxs_prev_q && !rxs_q;
    assign w_expire     = (bit_cnt_q <= c_bit_w'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            settle_q    <= 3'b000;
            rx_state_q  <= c_st_idle;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            ps_q        <= c_ps_wait_addr;
            addr_q      <= '0;
            to_cnt_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            link_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rxs_q       <= rxs_d;
            rxs_prev_q  <= rxs_prev_d;
            settle_q    <= settle_d;
            rx_state_q  <= rx_state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            ps_q        <= ps_d;
            addr_q      <= addr_d;
            to_cnt_q    <= to_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            link_cnt_q  <= link_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // Receiver next-state
    always_comb begin
        rx_state_d = rx_state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        case (rx_state_q)
            c_st_idle: begin
                if (w_start_edge) begin
                    rx_state_d = c_st_start;
                    bit_cnt_d  = c_bit_w'(c_half);
                end
            end
            c_st_start: begin
                if (w_expire) begin
                    if (!rxs_q) begin
                        rx_state_d = c_st_data;
                        bit_cnt_d  = c_bit_w'(c_baud_div);
                        bit_idx_d  = 3'd0;
                    end else begin
                        rx_state_d = c_st_idle;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - c_bit_w'(1);
                end
            end
            c_st_data: begin
                if (w_expire) begin
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_cnt_d = c_bit_w'(c_baud_div);
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = c_st_stop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - c_bit_w'(1);
                end
            end
            c_st_stop: begin
                if (w_expire) begin
                    rx_state_d = rxs_q ? c_st_idle : c_st_break;
                end else begin
                    bit_cnt_d = bit_cnt_q - c_bit_w'(1);
                end
            end
            c_st_break: begin
                if (rxs_q) begin
                    rx_state_d = c_st_idle;
                end
            end
            default: rx_state_d = c_st_idle;
        endcase
    end

    // Receiver outputs: byte completion events in the stop-sample cycle
    always_comb begin
        w_byte_valid = (rx_state_q == c_st_stop) && w_expire && rxs_q;
        w_frame_bad  = (rx_state_q == c_st_stop) && w_expire && !rxs_q;
    end

    // Parser next-state
    always_comb begin
        ps_d     = ps_q;
        addr_d   = addr_q;
        to_cnt_d = '0;
        case (ps_q)
            c_ps_wait_addr: begin
                if (w_byte_valid && shift_q[7]) begin
                    addr_d = shift_q[ADDR_WIDTH-1:0];
                    ps_d   = c_ps_wait_data;
                end
            end
            c_ps_wait_data: begin
                // A byte completing on the timeout cycle still wins.
                if (w_byte_valid || w_frame_bad) begin
                    ps_d = c_ps_wait_addr;
                end else if (to_cnt_q == c_to_w'(c_timeout - 1)) begin
                    ps_d = c_ps_wait_addr;
                end else begin
                    to_cnt_d = to_cnt_q + c_to_w'(1);
                end
            end
            default: ps_d = c_ps_wait_addr;
        endcase
    end

    // Parser outputs
    always_comb begin
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = w_frame_bad;
        if ((ps_q == c_ps_wait_data) && w_byte_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = shift_q;
        end
    end

    // Link hold and heartbeat
    always_comb begin
        link_cnt_d  = link_cnt_q;
        blink_cnt_d = blink_cnt_q + c_blink_w'(1);
        blink_d     = blink_q;
        if (w_byte_valid) begin
            link_cnt_d = c_link_w'(LINK_CYCLES);
        end else if (link_cnt_q != '0) begin
            link_cnt_d = link_cnt_q - c_link_w'(1);
        end
        if (blink_cnt_q == c_blink_w'(c_blink_div - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign link      = (link_cnt_q != '0);
    assign blink     = blink_q;

endmodule
`default_nettype wire

// File: tb/tb_apu_serial_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_apu_serial_frontend
// Purpose  : Directed self-checking bench for apu_serial_frontend
//            (BAUD_DIV=16, HALF=8, timeout 256 cycles, link hold 100 cycles).
// Revision : 1.0  initial release
// ============================================================================
module tb_apu_serial_frontend;

    localparam int BIT = 16;
    localparam int AW  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_err;
    logic          link;
    logic          blink;

    apu_serial_frontend #(
        .CLKRATE      (1600),
        .BAUDRATE     (100),
        .ADDR_WIDTH   (AW),
        .TIMEOUT_BITS (16),
        .LINK_CYCLES  (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .link      (link),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_vec = 0;
    int         n_err = 0;
    int         wr_cnt = 0, fe_cnt = 0;
    int         last_wr_cyc = -1, last_fe_cyc = -1;
    int         link_rise = -1, link_fall = -1;
    int         blink_tog = 0, blink_t0 = -1, blink_t1 = -1;
    logic [7:0] last_addr = '0, last_data = '0;
    logic       link_prev = 1'b0, blink_prev = 1'b0;

    // Event log sampled mid-cycle
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            last_addr   = 8'(wr_addr);
            last_data   = wr_data;
            last_wr_cyc = cyc;
        end
        if (frame_err) begin
            fe_cnt++;
            last_fe_cyc = cyc;
        end
        if (link && !link_prev) link_rise = cyc;
        if (!link && link_prev) link_fall = cyc;
        link_prev = link;
        if (blink != blink_prev) begin
            if (blink_tog == 0) blink_t0 = cyc;
            else if (blink_tog == 1) blink_t1 = cyc;
            blink_tog++;
        end
        blink_prev = blink;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame starting now; stop_low holds the stop bit low for
    // that many bit periods followed by one idle bit period.
    task automatic send_byte(input logic [7:0] b, input int stop_low, output int t0);
        t0 = cyc;
        rx = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(BIT);
        end
        if (stop_low > 0) begin
            rx = 1'b0;
            wait_cycles(stop_low * BIT);
        end
        rx = 1'b1;
        wait_cycles(BIT);
    endtask

    initial begin
        int t0, t1, tb, r0, w0, f0;

        // Reset state
        wait_cycles(5);
        chk("reset_outputs", {wr_en, wr_addr, wr_data, frame_err, link, blink}, 32'd0);
        rst = 1'b0;
        r0  = cyc;
        wait_cycles(10);
        chk("idle_outputs", {wr_en, wr_addr, wr_data, frame_err, link, blink}, 32'd0);

        // Single write 0x83, 0x5A
        send_byte(8'h83, 0, t0);
        chk("link_rise_cycle", link_rise, t0 + 155);
        chk("no_write_after_addr", wr_cnt, 0);
        send_byte(8'h5A, 0, t1);
        chk("single_wr_count", wr_cnt, 1);
        chk("single_wr_addr", last_addr, 8'h03);
        chk("single_wr_data", last_data, 8'h5A);
        chk("single_wr_cycle", last_wr_cyc, t1 + 155);
        wait_cycles(120);
        chk("link_fall_cycle", link_fall, t1 + 255);
        chk("link_low_idle", link, 1'b0);

        // Resync: leading bytes with bit7=0 ignored
        w0 = wr_cnt;
        send_byte(8'h12, 0, t0);
        send_byte(8'h07, 0, t0);
        send_byte(8'h9F, 0, t0);
        send_byte(8'hFF, 0, t0);
        chk("resync_wr_count", wr_cnt - w0, 1);
        chk("resync_wr_addr", last_addr, 8'h1F);
        chk("resync_wr_data", last_data, 8'hFF);

        // Framing error aborts the pending packet
        w0 = wr_cnt;
        f0 = fe_cnt;
        send_byte(8'h81, 0, t0);
        send_byte(8'h22, 3, tb);
        chk("fe_no_write", wr_cnt - w0, 0);
        send_byte(8'h81, 0, t0);
        send_byte(8'h44, 0, t0);
        chk("fe_count", fe_cnt - f0, 1);
        chk("fe_cycle", last_fe_cyc, tb + 155);
        chk("fe_wr_count", wr_cnt - w0, 1);
        chk("fe_wr_addr", last_addr, 8'h01);
        chk("fe_wr_data", last_data, 8'h44);

        // Heartbeat toggles every 800 cycles from reset release
        chk("blink_first_toggle", blink_t0, r0 + 800);
        chk("blink_second_toggle", blink_t1, r0 + 1600);

        // Glitch inside a packet must not produce a byte
        w0 = wr_cnt;
        f0 = fe_cnt;
        send_byte(8'h82, 0, t0);
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(20);
        send_byte(8'h66, 0, t0);
        chk("glitch_no_fe", fe_cnt - f0, 0);
        chk("glitch_wr_count", wr_cnt - w0, 1);
        chk("glitch_wr_addr", last_addr, 8'h02);
        chk("glitch_wr_data", last_data, 8'h66);

        // Timeout: data byte arrives too late and is then ignored
        w0 = wr_cnt;
        send_byte(8'h85, 0, t0);
        wait_cycles(17 * BIT);
        send_byte(8'h33, 0, t0);
        wait_cycles(20);
        chk("timeout_no_write", wr_cnt - w0, 0);

        // Reset during data bit 4 of 0x2F (bit4=0, line low through reset)
        send_byte(8'h81, 0, t0);
        rx = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            wait_cycles(BIT);
        end
        rx = 1'b0;
        wait_cycles(8);
        chk("pre_reset_link_high", link, 1'b1);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        chk("post_reset_outputs", {wr_en, wr_addr, wr_data, frame_err, link, blink}, 32'd0);
        w0 = wr_cnt;
        f0 = fe_cnt;
        wait_cycles(40);
        rx = 1'b1;
        wait_cycles(2 * BIT);
        send_byte(8'h84, 0, t0);
        send_byte(8'h10, 0, t0);
        wait_cycles(20);
        chk("rst_no_fe", fe_cnt - f0, 0);
        chk("rst_wr_count", wr_cnt - w0, 1);
        chk("rst_wr_addr", last_addr, 8'h04);
        chk("rst_wr_data", last_data, 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
